// File: rtl/uart_seq_pkg.sv
// Shared types for the UART port sequencer: command and FSM state
// encodings, rate-select constants and grant bit positions.
package uart_seq_pkg;

    typedef enum logic [1:0] {
        CMD_IDLE  = 2'd0,
        CMD_TX    = 2'd1,
        CMD_RX    = 2'd2,
        CMD_CLEAR = 2'd3
    } cmd_e;

    typedef enum logic [1:0] {
        ST_ARB     = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2
    } state_e;

    localparam logic [1:0] RATE_9600   = 2'b00;
    localparam logic [1:0] RATE_19200  = 2'b01;
    localparam logic [1:0] RATE_38400  = 2'b10;
    localparam logic [1:0] RATE_115200 = 2'b11;

    // One-hot grant vector bit positions
    localparam int GNT_CLR = 0;
    localparam int GNT_TX  = 1;
    localparam int GNT_RX  = 2;

endpackage

// File: rtl/uart_seq_arbiter.sv
// Grant selection for the UART port sequencer.
// Ports: clr_req/tx_req/rx_req requests, rr_ptr (0=TX next, 1=RX next),
// grant one-hot [CLR,TX,RX]. Macro UART_SEQ_RR_EN enables TX/RX round-robin.
import uart_seq_pkg::*;

module uart_seq_arbiter (
    input  logic       clr_req,
    input  logic       tx_req,
    input  logic       rx_req,
    input  logic       rr_ptr,
    output logic [2:0] grant
);

`ifndef UART_SEQ_RR_EN
    // Pointer only matters in the round-robin build
    logic unused_rr_ptr;
    assign unused_rr_ptr = rr_ptr;
`endif

    always_comb begin
        grant = '0;
        if (clr_req) begin
            grant[GNT_CLR] = 1'b1;
        end else if (tx_req && rx_req) begin
`ifdef UART_SEQ_RR_EN
            if (rr_ptr) grant[GNT_RX] = 1'b1;
            else        grant[GNT_TX] = 1'b1;
`else
            grant[GNT_TX] = 1'b1;
`endif
        end else if (tx_req) begin
            grant[GNT_TX] = 1'b1;
        end else if (rx_req) begin
            grant[GNT_RX] = 1'b1;
        end
    end

endmodule

// File: rtl/uart_port_sequencer.sv
// Sequences TX writes, RX reads and buffer clears onto a UART control port
// as ARB -> ISSUE -> CAPTURE, one operation per three cycles.
// Ports: clk, reset (sync, active-high), cfg_rate/cfg_we rate register,
// tx_req_* / rx_req_* / rx_rsp_* requesters, clr_req/clr_ack,
// uart_control {cmd,rate}, uart_tx_data, uart_rx_data, busy.
// Macro UART_SEQ_RR_EN selects TX/RX round-robin instead of TX priority.
import uart_seq_pkg::*;

module uart_port_sequencer #(
    parameter logic [1:0] RATE_RESET = 2'b00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] cfg_rate,
    input  logic       cfg_we,
    input  logic       tx_req_valid,
    input  logic [7:0] tx_req_data,
    output logic       tx_req_ready,
    input  logic       rx_req_valid,
    output logic       rx_req_ready,
    output logic       rx_rsp_valid,
    output logic [7:0] rx_rsp_data,
    input  logic       clr_req,
    output logic       clr_ack,
    output logic [3:0] uart_control,
    output logic [7:0] uart_tx_data,
    input  logic [7:0] uart_rx_data,
    output logic       busy
);

    state_e     state_q, state_d;
    cmd_e       cmd_q, cmd_d;
    logic [7:0] data_q, data_d;
    logic [1:0] rate_q, rate_d;
    logic       rr_ptr_q, rr_ptr_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic [7:0] rsp_data_q, rsp_data_d;

    logic [2:0] grant;
    logic       arb_open;
    logic       accept;

    uart_seq_arbiter u_arb (
        .clr_req (clr_req),
        .tx_req  (tx_req_valid),
        .rx_req  (rx_req_valid),
        .rr_ptr  (rr_ptr_q),
        .grant   (grant)
    );

    // Handshakes open only in ARB and never while reset is asserted
    assign arb_open     = (state_q == ST_ARB) && !reset;
    assign clr_ack      = arb_open && grant[GNT_CLR];
    assign tx_req_ready = arb_open && grant[GNT_TX];
    assign rx_req_ready = arb_open && grant[GNT_RX];
    assign accept       = clr_ack || tx_req_ready || rx_req_ready;

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        data_d      = data_q;
        rate_d      = rate_q;
        rr_ptr_d    = rr_ptr_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;

        if (cfg_we) rate_d = cfg_rate;

        unique case (state_q)
            ST_ARB: begin
                if (accept) begin
                    state_d = ST_ISSUE;
                    data_d  = '0;
                    unique case (1'b1)
                        grant[GNT_CLR]: cmd_d = CMD_CLEAR;
                        grant[GNT_TX]: begin
                            cmd_d    = CMD_TX;
                            data_d   = tx_req_data;
                            rr_ptr_d = 1'b1;
                        end
                        grant[GNT_RX]: begin
                            cmd_d    = CMD_RX;
                            rr_ptr_d = 1'b0;
                        end
                        default: cmd_d = CMD_IDLE;
                    endcase
                end
            end
            ST_ISSUE: state_d = ST_CAPTURE;
            ST_CAPTURE: begin
                state_d = ST_ARB;
                // RX byte sampled on the edge that leaves CAPTURE
                if (cmd_q == CMD_RX) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = uart_rx_data;
                end
            end
            default: state_d = ST_ARB;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_ARB;
            cmd_q       <= CMD_IDLE;
            data_q      <= '0;
            rate_q      <= RATE_RESET;
            rr_ptr_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            data_q      <= data_d;
            rate_q      <= rate_d;
            rr_ptr_q    <= rr_ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    // Command visible in ISSUE only, so the UART always sees an IDLE gap
    assign uart_control = {(state_q == ST_ISSUE) ? cmd_q : CMD_IDLE, rate_q};
    assign uart_tx_data = (state_q != ST_ARB) ? data_q : 8'h00;
    assign rx_rsp_valid = rsp_valid_q;
    assign rx_rsp_data  = rsp_data_q;
    assign busy         = (state_q != ST_ARB);

endmodule

// File: tb/tb_uart_port_sequencer.sv
// Directed testbench for uart_port_sequencer with immediate-assertion checks.
// Expectations follow UART_SEQ_RR_EN when it is defined.
module tb_uart_port_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] cfg_rate;
    logic       cfg_we;
    logic       tx_req_valid;
    logic [7:0] tx_req_data;
    logic       tx_req_ready;
    logic       rx_req_valid;
    logic       rx_req_ready;
    logic       rx_rsp_valid;
    logic [7:0] rx_rsp_data;
    logic       clr_req;
    logic       clr_ack;
    logic [3:0] uart_control;
    logic [7:0] uart_tx_data;
    logic [7:0] uart_rx_data;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    uart_port_sequencer #(.RATE_RESET(2'b00)) dut (
        .clk          (clk),
        .reset        (reset),
        .cfg_rate     (cfg_rate),
        .cfg_we       (cfg_we),
        .tx_req_valid (tx_req_valid),
        .tx_req_data  (tx_req_data),
        .tx_req_ready (tx_req_ready),
        .rx_req_valid (rx_req_valid),
        .rx_req_ready (rx_req_ready),
        .rx_rsp_valid (rx_rsp_valid),
        .rx_rsp_data  (rx_rsp_data),
        .clr_req      (clr_req),
        .clr_ack      (clr_ack),
        .uart_control (uart_control),
        .uart_tx_data (uart_tx_data),
        .uart_rx_data (uart_rx_data),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        cfg_rate = 2'b00;
        cfg_we = 1'b0;
        tx_req_valid = 1'b1;
        tx_req_data = 8'h00;
        rx_req_valid = 1'b1;
        clr_req = 1'b1;
        uart_rx_data = 8'h00;

        // Reset state, handshakes suppressed while reset is high
        cyc();
        cyc();
        chk("rst_tx_ready", 8'(tx_req_ready), 8'h0);
        chk("rst_rx_ready", 8'(rx_req_ready), 8'h0);
        chk("rst_clr_ack", 8'(clr_ack), 8'h0);
        chk("rst_control", 8'(uart_control), 8'h0);
        chk("rst_tx_data", uart_tx_data, 8'h00);
        chk("rst_rsp_valid", 8'(rx_rsp_valid), 8'h0);
        chk("rst_rsp_data", rx_rsp_data, 8'h00);
        chk("rst_busy", 8'(busy), 8'h0);

        // TX 0xA5
        reset = 1'b0;
        clr_req = 1'b0;
        rx_req_valid = 1'b0;
        tx_req_data = 8'hA5;
        #1;
        chk("tx_ready_arb", 8'(tx_req_ready), 8'h1);
        cyc();
        tx_req_valid = 1'b0;
        tx_req_data = 8'h00;
        chk("tx_issue_ctrl", 8'(uart_control), 8'h04);
        chk("tx_issue_data", uart_tx_data, 8'hA5);
        chk("tx_issue_busy", 8'(busy), 8'h1);
        cyc();
        chk("tx_cap_ctrl", 8'(uart_control), 8'h00);
        chk("tx_cap_data", uart_tx_data, 8'hA5);
        cyc();
        chk("tx_arb_data", uart_tx_data, 8'h00);
        chk("tx_arb_busy", 8'(busy), 8'h0);
        tx_req_valid = 1'b1;
        #1;
        chk("tx_ready_t3", 8'(tx_req_ready), 8'h1);
        tx_req_valid = 1'b0;

        // RX with rate write during ISSUE
        rx_req_valid = 1'b1;
        #1;
        chk("rx_ready_arb", 8'(rx_req_ready), 8'h1);
        cyc();
        rx_req_valid = 1'b0;
        chk("rx_issue_ctrl", 8'(uart_control), 8'h08);
        cfg_rate = 2'b11;
        cfg_we = 1'b1;
        cyc();
        cfg_we = 1'b0;
        chk("cfg_rate_ctrl", 8'(uart_control), 8'h03);
        uart_rx_data = 8'h3C;
        chk("rx_cap_nvalid", 8'(rx_rsp_valid), 8'h0);
        cyc();
        chk("rx_rsp_valid", 8'(rx_rsp_valid), 8'h1);
        chk("rx_rsp_data", rx_rsp_data, 8'h3C);
        cyc();
        chk("rx_rsp_pulse", 8'(rx_rsp_valid), 8'h0);

        // Clear beats TX and RX
        clr_req = 1'b1;
        tx_req_valid = 1'b1;
        tx_req_data = 8'h5A;
        rx_req_valid = 1'b1;
        #1;
        chk("all_clr_ack", 8'(clr_ack), 8'h1);
        chk("all_tx_ready", 8'(tx_req_ready), 8'h0);
        chk("all_rx_ready", 8'(rx_req_ready), 8'h0);
        cyc();
        clr_req = 1'b0;
        chk("clr_issue_ctrl", 8'(uart_control), 8'h0F);
        cyc();
        chk("clr_cap_ctrl", 8'(uart_control), 8'h03);
        cyc();
        chk("arb1_tx_ready", 8'(tx_req_ready), 8'h1);
        chk("arb1_rx_ready", 8'(rx_req_ready), 8'h0);
        cyc();
        chk("arb1_issue_ctrl", 8'(uart_control), 8'h07);
        chk("arb1_issue_data", uart_tx_data, 8'h5A);
        cyc();
        cyc();
`ifdef UART_SEQ_RR_EN
        chk("arb2_tx_ready", 8'(tx_req_ready), 8'h0);
        chk("arb2_rx_ready", 8'(rx_req_ready), 8'h1);
        cyc();
        chk("arb2_issue_ctrl", 8'(uart_control), 8'h0B);
`else
        chk("arb2_tx_ready", 8'(tx_req_ready), 8'h1);
        chk("arb2_rx_ready", 8'(rx_req_ready), 8'h0);
        cyc();
        chk("arb2_issue_ctrl", 8'(uart_control), 8'h07);
`endif
        cyc();
        cyc();
        chk("arb3_tx_ready", 8'(tx_req_ready), 8'h1);
        chk("arb3_rx_ready", 8'(rx_req_ready), 8'h0);
        tx_req_valid = 1'b0;
        rx_req_valid = 1'b0;
        cyc();
        cyc();
        cyc();

        // Reset during CAPTURE of an RX op
        chk("pre_rst_busy", 8'(busy), 8'h0);
        rx_req_valid = 1'b1;
        uart_rx_data = 8'hC3;
        cyc();
        rx_req_valid = 1'b0;
        cyc();
        chk("abort_cap_busy", 8'(busy), 8'h1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("abort_nvalid", 8'(rx_rsp_valid), 8'h0);
        chk("abort_control", 8'(uart_control), 8'h00);
        chk("abort_tx_data", uart_tx_data, 8'h00);
        chk("abort_busy", 8'(busy), 8'h0);
        chk("abort_rsp_data", rx_rsp_data, 8'h00);
        cyc();
        chk("abort_nvalid2", 8'(rx_rsp_valid), 8'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
